lesq_pipe: RTL and testbench
============================

LESQ_PIPE -- requirements
Module: lesq_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, input operand width; even, 8..64.
REQ-002 SHALL have parameter TAG_W, default 4, sideband tag width carried alongside each operand.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operand present.
REQ-006 SHALL have port in_ready  output  1  operand accepted when in_valid && in_ready.
REQ-007 SHALL have port in_data  input  WIDTH  unsigned radicand x.
REQ-008 SHALL have port in_tag  input  TAG_W  opaque tag.
REQ-009 SHALL have port out_valid  output  1  result present.
REQ-010 SHALL have port out_ready  input  1  result consumed when out_valid && out_ready.
REQ-011 SHALL have port out_sqrt  output  WIDTH/2  approximate square root.
REQ-012 SHALL have port out_tag  output  TAG_W  tag of the same operand.
REQ-013 SHALL have port out_zero  output  1  set when x == 0.

Function
REQ-014 SHALL compute k = index of leading one of x, r = x - 2^k, p = floor(k/2), odd = k[0].
REQ-015 SHALL compute Q = 2^p + (r >> (p+1)), in WIDTH/2+1 bits internally.
REQ-016 SHALL, for odd k with compensation compiled in, add 2^m, m = max(((k+1)>>1) - 3, 0); no addition for even k.
REQ-017 SHALL saturate the final sum to all-ones WIDTH/2 on overflow.
REQ-018 SHALL output out_sqrt = 0 and out_zero = 1 for x == 0; out_zero = 0 otherwise.
REQ-019 SHALL be a 3-stage pipeline: S1 leading-one detect, k, r; S2 shift and base add (Q); S3 compensation add and saturation.
REQ-020 SHALL have latency 3 cycles from acceptance to out_valid with out_ready held high; throughput 1 per cycle.
REQ-021 SHALL advance each stage when its successor is empty or advancing; in_ready = !S1_valid || S1 advancing (combinational from out_ready permitted).
REQ-022 SHALL hold out_sqrt, out_tag, out_zero stable while out_valid && !out_ready.
REQ-023 SHALL preserve order; no result dropped or duplicated under any back-pressure pattern; capacity exactly 3.
REQ-024 SHALL accept a new operand and retire a result in the same cycle when full and out_ready high.

Reset
REQ-025 SHALL clear all stage valid bits on rst; out_valid = 0, out_sqrt = 0, out_tag = 0, out_zero = 0 the cycle after rst sampled high.
REQ-026 SHALL discard in-flight operands on rst mid-operation; in_ready = 0 while rst high.

Configuration
REQ-027 SHALL compile odd-k error compensation (REQ-016) when macro LESQ_ERR_COMP_EN is defined.
REQ-028 SHALL, without LESQ_ERR_COMP_EN, output S3 = saturated Q with latency still 3 cycles.

Structure
REQ-029 SHALL place constants LESQ_LAT = 3, LESQ_COMP_OFS = 3 and the stage-payload struct typedef in package lesq_pkg.
REQ-030 SHALL instantiate one sub-module lesq_lod (parametrised leading-one detector: WIDTH in, $clog2(WIDTH) index out, nonzero flag).

Verification (WIDTH=32, out_ready high unless stated)
REQ-031 SHALL check x=16 -> out_sqrt 4; x=100 -> 10 (k=6,p=3,r=36); each 3 cycles after acceptance, tag echoed.
REQ-032 SHALL check x=8 -> 3 and x=2 -> 2 with LESQ_ERR_COMP_EN; 2 and 1 without.
REQ-033 SHALL check x=0 -> out_sqrt 0, out_zero 1; x=0xFFFFFFFF -> 0xFFFF (saturated with compensation).
REQ-034 SHALL check out_ready low, 5 operands offered back-to-back -> 3 accepted, in_ready low, output stable; out_ready high -> tags 0,1,2,3,4 in order.
REQ-035 SHALL check rst asserted with 3 in flight -> out_valid 0 next cycle, no stale results after release.
REQ-036 SHALL check 1000 random operands with random valid/ready against reference model bit-exact, both macro settings.

Source files
------------

// File: rtl/lesq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : lesq_pkg
// Purpose : Shared constants, stage-payload type and compensation helper for
//           the lesq_pipe approximate square-root pipeline.
// Contents: LESQ_LAT       - pipeline latency in cycles
//           LESQ_COMP_OFS  - offset subtracted from (k+1)>>1 for odd-k bias
//           LESQ_SHIFT_W   - width of shift amounts (covers WIDTH up to 64)
//           lesq_stage_t   - per-stage control payload (valid, zero flag)
//           lesq_comp_shift- exponent m of the odd-k compensation term
// Revision: 1.0 - initial release
// ============================================================================
package lesq_pkg;

  localparam int LESQ_LAT      = 3;
  localparam int LESQ_COMP_OFS = 3;
  localparam int LESQ_SHIFT_W  = 6;

  typedef struct packed {
    logic valid;
    logic zero;
  } lesq_stage_t;

  // p = floor(k/2); for odd k, (k+1)>>1 == p+1. Result is clamped at zero.
  function automatic logic [LESQ_SHIFT_W-1:0] lesq_comp_shift(
    input logic [LESQ_SHIFT_W-1:0] p
  );
    logic [LESQ_SHIFT_W-1:0] half;
    half = p + LESQ_SHIFT_W'(1);
    if (half >= LESQ_SHIFT_W'(LESQ_COMP_OFS))
      return half - LESQ_SHIFT_W'(LESQ_COMP_OFS);
    return '0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lesq_lod.sv
`default_nettype none
// ============================================================================
// Module  : lesq_lod
// Purpose : Combinational leading-one detector.
// Ports   : vec     [WIDTH-1:0] in  - vector to scan
//           idx     [IDX_W-1:0] out - index of the most significant set bit
//                                     (0 when vec is all zeros)
//           nonzero             out - 1 when any bit of vec is set
// Revision: 1.0 - initial release
// ============================================================================
module lesq_lod
  import lesq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             nonzero
);

  // Ascending scan: the last set bit seen is the leading one.
  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

  assign nonzero = |vec;

endmodule
`default_nettype wire

// File: rtl/lesq_pipe.sv
`default_nettype none
// ============================================================================
// Module  : lesq_pipe
// Purpose : 3-stage valid/ready pipeline computing an approximate square root
//           of an unsigned WIDTH-bit operand with a tag carried alongside.
//             S1: leading-one index k, remainder r = x - 2^k
//             S2: Q = 2^p + (r >> (p+1)), p = floor(k/2)
//             S3: optional odd-k compensation add, saturation to WIDTH/2 bits
// Config  : define LESQ_ERR_COMP_EN to add 2^m for odd k,
//           m = max(((k+1)>>1) - 3, 0). Latency is 3 cycles either way.
// Ports   : clk, rst (sync, active-high)
//           in_valid/in_ready, in_data[WIDTH-1:0], in_tag[TAG_W-1:0]
//           out_valid/out_ready, out_sqrt[WIDTH/2-1:0], out_tag[TAG_W-1:0],
//           out_zero (operand was zero)
// Revision: 1.0 - initial release
// ============================================================================
module lesq_pipe
  import lesq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH/2-1:0] out_sqrt,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_zero
);

  localparam int HALF = WIDTH / 2;
  localparam int KW   = $clog2(WIDTH);

  // ---------------- stage registers ----------------
  lesq_stage_t       s1_st;
  logic [KW-1:0]     s1_k;
  logic [WIDTH-1:0]  s1_rem;
  logic [TAG_W-1:0]  s1_tag;

  lesq_stage_t       s2_st;
  logic [HALF:0]     s2_q;
  logic [TAG_W-1:0]  s2_tag;
`ifdef LESQ_ERR_COMP_EN
  logic              s2_odd;
  logic [KW-1:0]     s2_p;
`endif

  lesq_stage_t       s3_st;

  // ---------------- flow control ----------------
  logic adv1, adv2, adv3;

  assign adv3      = !s3_st.valid || out_ready;
  assign adv2      = !s2_st.valid || adv3;
  assign adv1      = !s1_st.valid || adv2;
  assign in_ready  = adv1 && !rst;
  assign out_valid = s3_st.valid;
  assign out_zero  = s3_st.zero;

  // ---------------- S1 combinational ----------------
  logic [KW-1:0]    lod_idx;
  logic             lod_nz;
  logic [WIDTH-1:0] rem_in;

  lesq_lod #(
    .WIDTH (WIDTH),
    .IDX_W (KW)
  ) u_lod (
    .vec     (in_data),
    .idx     (lod_idx),
    .nonzero (lod_nz)
  );

  // Clearing the leading one yields x - 2^k; a zero operand stays zero.
  assign rem_in = in_data & ~(WIDTH'(1) << lod_idx);

  // ---------------- S2 combinational ----------------
  logic [KW-1:0]    s1_p;
  logic [WIDTH-1:0] s1_shr;
  logic [HALF:0]    q_next;

  always_comb begin
    s1_p   = s1_k >> 1;
    s1_shr = (s1_rem >> s1_p) >> 1;
    // r < 2^k, so r >> (p+1) < 2^p and the sum stays below 2^HALF.
    q_next = (HALF+1)'(s1_shr) + ((HALF+1)'(1) << s1_p);
  end

  // ---------------- S3 combinational ----------------
  logic [HALF:0]   comp;
  logic [HALF:0]   sum;
  logic [HALF-1:0] res;

  always_comb begin
`ifdef LESQ_ERR_COMP_EN
    comp = s2_odd ? ((HALF+1)'(1) << lesq_comp_shift(LESQ_SHIFT_W'(s2_p)))
                  : '0;
`else
    comp = '0;
`endif
    sum = s2_q + comp;
    if (s2_st.zero)
      res = '0;
    else if (sum[HALF])
      res = '1;
    else
      res = sum[HALF-1:0];
  end

  // ---------------- pipeline registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_st    <= '0;
      s1_k     <= '0;
      s1_rem   <= '0;
      s1_tag   <= '0;
      s2_st    <= '0;
      s2_q     <= '0;
      s2_tag   <= '0;
`ifdef LESQ_ERR_COMP_EN
      s2_odd   <= 1'b0;
      s2_p     <= '0;
`endif
      s3_st    <= '0;
      out_sqrt <= '0;
      out_tag  <= '0;
    end else begin
      if (adv1) begin
        s1_st.valid <= in_valid;
        if (in_valid) begin
          s1_st.zero <= !lod_nz;
          s1_k       <= lod_idx;
          s1_rem     <= rem_in;
          s1_tag     <= in_tag;
        end
      end
      if (adv2) begin
        s2_st.valid <= s1_st.valid;
        if (s1_st.valid) begin
          s2_st.zero <= s1_st.zero;
          s2_q       <= q_next;
          s2_tag     <= s1_tag;
`ifdef LESQ_ERR_COMP_EN
          s2_odd     <= s1_k[0];
          s2_p       <= s1_p;
`endif
        end
      end
      // Output registers only change when S3 advances, so they hold
      // steady while a result waits for out_ready.
      if (adv3) begin
        s3_st.valid <= s2_st.valid;
        if (s2_st.valid) begin
          s3_st.zero <= s2_st.zero;
          out_sqrt   <= res;
          out_tag    <= s2_tag;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lesq_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_lesq_pipe
// Purpose : Self-checking bench for lesq_pipe (WIDTH=32, TAG_W=4). Expected
//           values follow LESQ_ERR_COMP_EN when it is defined.
// Revision: 1.0 - initial release
// ============================================================================
module tb_lesq_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sqrt;
  logic [3:0]  out_tag;
  logic        out_zero;

  lesq_pipe #(.WIDTH(32), .TAG_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sqrt  (out_sqrt),
    .out_tag   (out_tag),
    .out_zero  (out_zero)
  );

  always #5 clk = ~clk;

`ifdef LESQ_ERR_COMP_EN
  localparam logic [15:0] E8 = 16'd3, E2 = 16'd2, E3 = 16'd2, E255 = 16'd17;
  localparam logic [15:0] E1M = 16'd1104, E80 = 16'hA000;
`else
  localparam logic [15:0] E8 = 16'd2, E2 = 16'd1, E3 = 16'd1, E255 = 16'd15;
  localparam logic [15:0] E1M = 16'd976, E80 = 16'h8000;
`endif

  typedef struct {
    logic [31:0] x;
    logic [3:0]  tag;
    logic [15:0] exp_sqrt;
    logic        exp_zero;
  } vec_t;

  typedef struct {
    logic [15:0] sqrt;
    logic [3:0]  tag;
    logic        zero;
  } res_t;

  int   checks = 0;
  int   errors = 0;
  res_t sb[$];
  bit   hold_valid;
  res_t held;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic res_t model(input logic [31:0] x, input logic [3:0] tag);
    res_t   r;
    int     k, p, m;
    longint rem, q;
    r.tag  = tag;
    r.zero = (x == 32'd0);
    r.sqrt = 16'd0;
    if (x == 32'd0) return r;
    k = 0;
    for (int i = 0; i < 32; i++) if (x[i]) k = i;
    rem = longint'(x) - (longint'(1) << k);
    p   = k / 2;
    q   = (longint'(1) << p) + (rem >> (p + 1));
`ifdef LESQ_ERR_COMP_EN
    if (k % 2 == 1) begin
      m = (k + 1) / 2 - 3;
      if (m < 0) m = 0;
      q = q + (longint'(1) << m);
    end
`else
    m = 0;
`endif
    if (q > 65535) q = 65535;
    r.sqrt = 16'(q);
    return r;
  endfunction

  // Inputs are set at a negedge; sample the handshakes just after, then
  // move on to the next negedge.
  task automatic step(output bit acc);
    res_t e;
    #1;
    if (hold_valid)
      check("hold_stable", {out_valid, out_sqrt, out_tag, out_zero},
            {1'b1, held.sqrt, held.tag, held.zero});
    acc = in_valid && in_ready;
    if (acc) sb.push_back(model(in_data, in_tag));
    if (out_valid && out_ready) begin
      hold_valid = 1'b0;
      check("sb_nonempty", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("out_result", {out_sqrt, out_tag, out_zero},
              {e.sqrt, e.tag, e.zero});
      end
    end else if (out_valid) begin
      hold_valid = 1'b1;
      held.sqrt  = out_sqrt;
      held.tag   = out_tag;
      held.zero  = out_zero;
    end else begin
      hold_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  vec_t        vt[12];
  logic [31:0] bp_x[5];
  logic [31:0] rx[3];
  logic [3:0]  rt[3];

  initial begin
    bit          a;
    int          nxt;
    int          stale;
    int          acc_cnt;
    int unsigned sh;
    logic [31:0] x;

    vt[0]  = '{32'd16,         4'd1,  16'd4,     1'b0};
    vt[1]  = '{32'd100,        4'd2,  16'd10,    1'b0};
    vt[2]  = '{32'd8,          4'd3,  E8,        1'b0};
    vt[3]  = '{32'd2,          4'd4,  E2,        1'b0};
    vt[4]  = '{32'd0,          4'd5,  16'd0,     1'b1};
    vt[5]  = '{32'hFFFFFFFF,   4'd6,  16'hFFFF,  1'b0};
    vt[6]  = '{32'd1,          4'd7,  16'd1,     1'b0};
    vt[7]  = '{32'd3,          4'd8,  E3,        1'b0};
    vt[8]  = '{32'd255,        4'd9,  E255,      1'b0};
    vt[9]  = '{32'd1000000,    4'd10, E1M,       1'b0};
    vt[10] = '{32'd64,         4'd11, 16'd8,     1'b0};
    vt[11] = '{32'h80000000,   4'd12, E80,       1'b0};
    bp_x   = '{32'd16, 32'd100, 32'd0, 32'd255, 32'd8};
    rx     = '{32'd0, 32'd100, 32'd16};
    rt     = '{4'd5, 4'd6, 4'd7};

    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    in_tag     = '0;
    out_ready  = 1'b1;
    hold_valid = 1'b0;

    // ---------------- reset state ----------------
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sqrt", out_sqrt, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_out_zero", out_zero, 0);
    rst = 1'b0;
    @(negedge clk);

    // ---------------- directed vectors, latency 3 ----------------
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1;
      in_data  = vt[i].x;
      in_tag   = vt[i].tag;
      #1 check($sformatf("v%0d_in_ready", i), in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      #1 check($sformatf("v%0d_lat1", i), out_valid, 0);
      @(negedge clk);
      #1 check($sformatf("v%0d_lat2", i), out_valid, 0);
      @(negedge clk);
      #1;
      check($sformatf("v%0d_valid", i), out_valid, 1);
      check($sformatf("v%0d_sqrt", i), out_sqrt, vt[i].exp_sqrt);
      check($sformatf("v%0d_tag", i), out_tag, vt[i].tag);
      check($sformatf("v%0d_zero", i), out_zero, vt[i].exp_zero);
    end
    @(negedge clk);

    // ---------------- back-pressure: capacity 3, ordering ----------------
    out_ready = 1'b0;
    nxt = 0;
    for (int c = 0; c < 8; c++) begin
      in_valid = (nxt < 5);
      in_data  = bp_x[nxt < 5 ? nxt : 0];
      in_tag   = 4'(nxt);
      step(a);
      if (a) nxt++;
    end
    check("bp_accepted", nxt, 3);
    #1;
    check("bp_in_ready_low", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    check("bp_out_tag", out_tag, 0);
    @(negedge clk);
    out_ready = 1'b1;
    for (int c = 0; c < 30 && (nxt < 5 || sb.size() > 0); c++) begin
      in_valid = (nxt < 5);
      in_data  = bp_x[nxt < 5 ? nxt : 0];
      in_tag   = 4'(nxt);
      step(a);
      if (a) nxt++;
    end
    in_valid = 1'b0;
    check("bp_all_accepted", nxt, 5);
    check("bp_drained", sb.size(), 0);
    repeat (2) @(negedge clk);

    // ---------------- reset with 3 in flight ----------------
    out_ready = 1'b0;
    nxt = 0;
    for (int c = 0; c < 6 && nxt < 3; c++) begin
      in_valid = 1'b1;
      in_data  = rx[nxt];
      in_tag   = rt[nxt];
      step(a);
      if (a) nxt++;
    end
    check("mr_fill", nxt, 3);
    #1;
    check("mr_pre_valid", out_valid, 1);
    check("mr_pre_zero", out_zero, 1);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'd16;
    in_tag   = 4'd9;
    #1 check("mr_in_ready_rst", in_ready, 0);
    @(negedge clk);
    #1;
    check("mr_out_valid", out_valid, 0);
    check("mr_out_sqrt", out_sqrt, 0);
    check("mr_out_tag", out_tag, 0);
    check("mr_out_zero", out_zero, 0);
    @(negedge clk);
    rst        = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    hold_valid = 1'b0;
    sb.delete();
    stale = 0;
    repeat (8) begin
      #1 if (out_valid) stale++;
      @(negedge clk);
    end
    check("mr_no_stale", stale, 0);

    // ---------------- random traffic vs model ----------------
    acc_cnt = 0;
    for (int c = 0; c < 20000 && (acc_cnt < 1000 || sb.size() > 0); c++) begin
      out_ready = ($urandom_range(0, 9) < 7);
      in_valid  = (acc_cnt < 1000) && ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 3))
        0: x = $urandom;
        1: x = $urandom >> $urandom_range(0, 31);
        2: x = 32'($urandom_range(0, 300));
        default: begin
          sh = $urandom_range(0, 31);
          x  = 32'd1 << sh;
          if ($urandom_range(0, 1) == 1) x = x | (x - 32'd1);
        end
      endcase
      in_data = x;
      in_tag  = 4'($urandom);
      step(a);
      if (a) acc_cnt++;
    end
    in_valid = 1'b0;
    check("rand_accepted", acc_cnt, 1000);
    check("rand_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
